// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width and range, and the ramp controller state encoding.
package pwm_pkg;
  localparam int DUTY_W = 7;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } pwm_state_e;
endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running divider that emits a one-cycle tick on its terminal count.
// clr restarts the count from zero, and en=0 freezes it.
module pwm_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear on the same edge wins, so a retarget never takes a stale step
  assign tick = en && !clr && (cnt_q == LAST);
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start / fade controller: walks the PWM duty toward a latched target
// by STEP every TICK_DIV clocks, with hold, stop and retarget support.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int STEP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              hold,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);
  localparam logic signed [7:0] STEP_S = 8'(STEP);

  function automatic logic [DUTY_W-1:0] clamp_target(input logic [DUTY_W-1:0] t);
    return (t > DUTY_MAX) ? DUTY_MAX : t;
  endfunction

  // Signed 8-bit distance so a downward move cannot wrap the 7-bit duty
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic signed [7:0] diff;
    logic signed [7:0] mag;
    logic signed [7:0] stp;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[7] ? -diff : diff;
    stp  = (mag < STEP_S) ? mag : STEP_S;
    return diff[7] ? (cur - stp[DUTY_W-1:0]) : (cur + stp[DUTY_W-1:0]);
  endfunction

  pwm_state_e        state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic              done_q;

  logic [DUTY_W-1:0] target_d;
  logic [DUTY_W-1:0] duty_d;
  logic              tick;
  logic              tick_clr;
  logic              tick_en;

  assign target_d = clamp_target(target_duty);
  assign duty_d   = step_toward(duty_q, target_q);
  assign tick_clr = stop || load || (state_q == ST_IDLE);
  assign tick_en  = ~hold;

  pwm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (tick_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        duty_q   <= '0;
        target_q <= '0;
        state_q  <= ST_IDLE;
      end else if (load) begin
        target_q <= target_d;
        if (target_d == duty_q) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RAMP;
        end
      end else if ((state_q == ST_RAMP) && tick) begin
        duty_q <= duty_d;
        if (duty_d == target_q) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign duty = duty_q;
  assign busy = (state_q == ST_RAMP);
  assign done = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl (TICK_DIV=4, STEP=10) with a
// cycle-stamped scoreboard of expected duty/busy/done values.
module tb_pwm_duty_ramp_ctrl;
  localparam int TICK_DIV = 4;
  localparam int STEP     = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       hold = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] target_duty = 7'd0;
  logic [6:0] duty;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    int         at;
    logic [6:0] duty;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  pwm_duty_ramp_ctrl #(
    .TICK_DIV(TICK_DIV),
    .STEP    (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .target_duty(target_duty),
    .hold       (hold),
    .stop       (stop),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int at, input int d, input logic b, input logic dn);
    exp_t e;
    e.at   = at;
    e.duty = 7'(d);
    e.busy = b;
    e.done = dn;
    sb.push_back(e);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_load(input int t, output int l);
    target_duty = 7'(t);
    load = 1'b1;
    l = cyc + 1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_stop(output int s);
    stop = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Monitor: runs just after each rising edge, cyc equals the edge number
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      chk("duty_le_100", 32'(duty <= 7'd100), 32'd1);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) chk("sb_late", 32'(cyc), 32'(e.at));
        chk($sformatf("c%0d_duty", e.at), 32'(duty), 32'(e.duty));
        chk($sformatf("c%0d_busy", e.at), 32'(busy), 32'(e.busy));
        chk($sformatf("c%0d_done", e.at), 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l;
    int l2;
    int s;
    int d0;

    // 1: reset, with a load pulse while reset is asserted
    @(negedge clk);
    pulse_load(50, l);
    step_to(3);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    expect_at(cyc + 1, 0, 1'b0, 1'b0);
    expect_at(cyc + 2, 0, 1'b0, 1'b0);
    step_to(cyc + 2);

    // 2: ramp 0 -> 35
    expect_at(cyc + 2, 0, 1'b1, 1'b0);
    expect_at(cyc + 4, 0, 1'b1, 1'b0);
    pulse_load(35, l);
    expect_at(l + 4, 10, 1'b1, 1'b0);
    expect_at(l + 8, 20, 1'b1, 1'b0);
    expect_at(l + 12, 30, 1'b1, 1'b0);
    expect_at(l + 16, 35, 1'b0, 1'b1);
    expect_at(l + 17, 35, 1'b0, 1'b0);
    step_to(l + 18);

    // 3: clamped target 120 -> 100
    expect_at(cyc + 1, 0, 1'b0, 1'b0);
    pulse_stop(s);
    d0 = done_cnt;
    pulse_load(120, l);
    for (int k = 1; k <= 10; k++) begin
      expect_at(l + 4 * k, (10 * k > 100) ? 100 : 10 * k, (k < 10), (k == 10));
    end
    expect_at(l + 41, 100, 1'b0, 1'b0);
    expect_at(l + 48, 100, 1'b0, 1'b0);
    step_to(l + 49);
    chk("clamp_done_once", 32'(done_cnt - d0), 32'd1);

    // 4: retarget downward mid-ramp
    expect_at(cyc + 1, 0, 1'b0, 1'b0);
    pulse_stop(s);
    pulse_load(80, l);
    for (int k = 1; k <= 4; k++) expect_at(l + 4 * k, 10 * k, 1'b1, 1'b0);
    step_to(l + 16);
    pulse_load(20, l2);
    expect_at(l2 + 3, 40, 1'b1, 1'b0);
    expect_at(l2 + 4, 30, 1'b1, 1'b0);
    expect_at(l2 + 7, 30, 1'b1, 1'b0);
    expect_at(l2 + 8, 20, 1'b0, 1'b1);
    expect_at(l2 + 9, 20, 1'b0, 1'b0);
    step_to(l2 + 10);

    // 5: hold at 30, then stop at 50
    expect_at(cyc + 1, 0, 1'b0, 1'b0);
    pulse_stop(s);
    pulse_load(90, l);
    for (int k = 1; k <= 3; k++) expect_at(l + 4 * k, 10 * k, 1'b1, 1'b0);
    step_to(l + 12);
    d0 = done_cnt;
    hold = 1'b1;
    expect_at(l + 16, 30, 1'b1, 1'b0);
    expect_at(l + 22, 30, 1'b1, 1'b0);
    expect_at(l + 25, 30, 1'b1, 1'b0);
    expect_at(l + 26, 40, 1'b1, 1'b0);
    expect_at(l + 30, 50, 1'b1, 1'b0);
    step_to(l + 22);
    hold = 1'b0;
    step_to(l + 30);
    expect_at(l + 31, 0, 1'b0, 1'b0);
    expect_at(l + 32, 0, 1'b0, 1'b0);
    expect_at(l + 36, 0, 1'b0, 1'b0);
    pulse_stop(s);
    step_to(l + 37);
    chk("stop_no_done", 32'(done_cnt - d0), 32'd0);

    // 6a: load equal to current duty while idle
    pulse_load(35, l);
    for (int k = 1; k <= 3; k++) expect_at(l + 4 * k, 10 * k, 1'b1, 1'b0);
    expect_at(l + 16, 35, 1'b0, 1'b1);
    step_to(l + 17);
    expect_at(cyc + 1, 35, 1'b0, 1'b1);
    expect_at(cyc + 2, 35, 1'b0, 1'b0);
    expect_at(cyc + 5, 35, 1'b0, 1'b0);
    pulse_load(35, l2);
    step_to(l2 + 5);

    // 6b: load on the tick edge discards that step
    expect_at(cyc + 1, 0, 1'b0, 1'b0);
    pulse_stop(s);
    pulse_load(50, l);
    expect_at(l + 4, 10, 1'b1, 1'b0);
    step_to(l + 7);
    expect_at(l + 8, 10, 1'b1, 1'b0);
    expect_at(l + 11, 10, 1'b1, 1'b0);
    expect_at(l + 12, 20, 1'b1, 1'b0);
    expect_at(l + 28, 60, 1'b0, 1'b1);
    pulse_load(60, l2);
    step_to(l + 30);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
